// File: rtl/clk_div_frac_mon.sv
// ---------------------------------------------------------------------------
// clk_div_frac_mon
//
// Receive-side health monitor for a fractional clock divider. The divider
// output (clk_div_in) is sampled in the source clock domain. Every output
// period is measured in source cycles. Each run of D_NUM consecutive periods
// is checked: the periods must sum to S_NUM, and exactly ACC of them must be
// long periods. The monitor reports lock, and it keeps sticky error flags.
//
// Short period = S_DIV = S_NUM / D_NUM cycles. Long period = D_DIV = S_DIV + 1.
// A correct divider only ever produces these two lengths. Because every
// D_NUM-period run of a correct divider sums to S_NUM, the window does not
// need to be aligned to the divider's pattern.
//
// Ports
//   clk         in   1      source clock (also drives the divider)
//   rst_n       in   1      asynchronous active-low reset
//   clk_div_in  in   1      divider output, already synchronous to clk
//   clr         in   1      synchronous clear: sticky flags, counters, state
//   period_len  out  CNT_W  last measured period, valid with period_vld
//   period_vld  out  1      one-cycle pulse per completed period
//   win_sum     out  SUM_W  sum of the last D_NUM periods, valid with win_vld
//   win_vld     out  1      one-cycle pulse per completed window
//   win_ok      out  1      window passed its check (qualifies win_vld)
//   lock        out  1      high while the monitor is in the LOCKED state
//   err_period  out  1      sticky: illegal period length or timeout
//   err_window  out  1      sticky: a window failed its check
// ---------------------------------------------------------------------------
module clk_div_frac_mon #(
    parameter  int S_NUM    = 76,
    parameter  int D_NUM    = 10,
    parameter  int LOCK_WIN = 2,
    localparam int S_DIV    = S_NUM / D_NUM,
    localparam int D_DIV    = S_DIV + 1,
    localparam int ACC      = S_NUM - S_DIV * D_NUM,
    localparam int CNT_W    = $clog2(D_DIV + 2),
    localparam int SUM_W    = $clog2(S_NUM + 1),
    localparam int NW       = $clog2(D_NUM + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_div_in,
    input  logic             clr,
    output logic [CNT_W-1:0] period_len,
    output logic             period_vld,
    output logic [SUM_W-1:0] win_sum,
    output logic             win_vld,
    output logic             win_ok,
    output logic             lock,
    output logic             err_period,
    output logic             err_window
);

    localparam int OK_W = $clog2(LOCK_WIN + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MEAS   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Registered state
    state_t           state_r;
    logic             d_r;
    logic [CNT_W-1:0] cnt_r;
    logic [SUM_W-1:0] sum_r;
    logic [NW-1:0]    n_long_r;
    logic [NW-1:0]    n_per_r;
    logic [OK_W-1:0]  ok_cnt_r;
    logic [CNT_W-1:0] period_len_r;
    logic             period_vld_r;
    logic [SUM_W-1:0] win_sum_r;
    logic             win_vld_r;
    logic             win_ok_r;
    logic             lock_r;
    logic             err_period_r;
    logic             err_window_r;

    // Next-state values
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [SUM_W-1:0] sum_nxt_s;
    logic [NW-1:0]    n_long_nxt_s;
    logic [NW-1:0]    n_per_nxt_s;
    logic [OK_W-1:0]  ok_cnt_nxt_s;
    logic [CNT_W-1:0] period_len_nxt_s;
    logic             period_vld_nxt_s;
    logic [SUM_W-1:0] win_sum_nxt_s;
    logic             win_vld_nxt_s;
    logic             win_ok_nxt_s;
    logic             lock_nxt_s;
    logic             err_period_nxt_s;
    logic             err_window_nxt_s;

    // Helper terms used when a rising edge closes a period
    logic             rise_s;
    logic [SUM_W-1:0] sum_add_s;
    logic [NW-1:0]    n_long_add_s;
    logic [NW-1:0]    n_per_add_s;
    logic             win_end_s;
    logic             win_good_s;
    logic             per_bad_s;
    logic [OK_W-1:0]  ok_inc_s;

    assign rise_s       = clk_div_in & ~d_r;
    assign sum_add_s    = sum_r + SUM_W'(cnt_r);
    assign n_long_add_s = n_long_r + ((cnt_r == CNT_W'(D_DIV)) ? NW'(1) : NW'(0));
    assign n_per_add_s  = n_per_r + NW'(1);
    assign win_end_s    = (n_per_add_s == NW'(D_NUM));
    assign win_good_s   = (sum_add_s == SUM_W'(S_NUM)) && (n_long_add_s == NW'(ACC));
    assign per_bad_s    = (cnt_r != CNT_W'(S_DIV)) && (cnt_r != CNT_W'(D_DIV));
    // The good-window count saturates at LOCK_WIN so it cannot wrap while locked
    assign ok_inc_s     = (ok_cnt_r >= OK_W'(LOCK_WIN - 1)) ? OK_W'(LOCK_WIN)
                                                            : (ok_cnt_r + OK_W'(1));

    // Next-state logic: measurement, window checking and lock tracking
    always_comb begin
        state_nxt_s      = state_r;
        cnt_nxt_s        = cnt_r;
        sum_nxt_s        = sum_r;
        n_long_nxt_s     = n_long_r;
        n_per_nxt_s      = n_per_r;
        ok_cnt_nxt_s     = ok_cnt_r;
        period_len_nxt_s = period_len_r;
        period_vld_nxt_s = 1'b0;
        win_sum_nxt_s    = win_sum_r;
        win_vld_nxt_s    = 1'b0;
        win_ok_nxt_s     = win_ok_r;
        err_period_nxt_s = err_period_r;
        err_window_nxt_s = err_window_r;

        if (clr) begin
            // Clear takes priority over any edge or window end in this cycle
            state_nxt_s      = ST_IDLE;
            cnt_nxt_s        = CNT_W'(0);
            sum_nxt_s        = SUM_W'(0);
            n_long_nxt_s     = NW'(0);
            n_per_nxt_s      = NW'(0);
            ok_cnt_nxt_s     = OK_W'(0);
            period_len_nxt_s = CNT_W'(0);
            win_sum_nxt_s    = SUM_W'(0);
            win_ok_nxt_s     = 1'b0;
            err_period_nxt_s = 1'b0;
            err_window_nxt_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // The first edge only starts timing; no period exists yet
                    if (rise_s) begin
                        cnt_nxt_s   = CNT_W'(1);
                        state_nxt_s = ST_MEAS;
                    end else begin
                        cnt_nxt_s   = cnt_r;
                    end
                end
                ST_MEAS, ST_LOCKED: begin
                    if (rise_s) begin
                        period_len_nxt_s = cnt_r;
                        period_vld_nxt_s = 1'b1;
                        cnt_nxt_s        = CNT_W'(1);
                        sum_nxt_s        = sum_add_s;
                        n_long_nxt_s     = n_long_add_s;
                        n_per_nxt_s      = n_per_add_s;
                        if (win_end_s) begin
                            win_vld_nxt_s = 1'b1;
                            win_sum_nxt_s = sum_add_s;
                            win_ok_nxt_s  = win_good_s;
                            sum_nxt_s     = SUM_W'(0);
                            n_long_nxt_s  = NW'(0);
                            n_per_nxt_s   = NW'(0);
                            if (win_good_s) begin
                                ok_cnt_nxt_s = ok_inc_s;
                                if (ok_inc_s == OK_W'(LOCK_WIN)) begin
                                    state_nxt_s = ST_LOCKED;
                                end else begin
                                    state_nxt_s = state_r;
                                end
                            end else begin
                                err_window_nxt_s = 1'b1;
                                ok_cnt_nxt_s     = OK_W'(0);
                                state_nxt_s      = ST_MEAS;
                            end
                        end else begin
                            win_vld_nxt_s = 1'b0;
                        end
                        // A bad period overrides any lock progress made above
                        if (per_bad_s) begin
                            err_period_nxt_s = 1'b1;
                            ok_cnt_nxt_s     = OK_W'(0);
                            state_nxt_s      = ST_MEAS;
                        end else begin
                            err_period_nxt_s = err_period_r;
                        end
                    end else if (cnt_r == CNT_W'(D_DIV + 1)) begin
                        // Timeout: the counter is held, and the partial window is discarded
                        err_period_nxt_s = 1'b1;
                        state_nxt_s      = ST_IDLE;
                        sum_nxt_s        = SUM_W'(0);
                        n_long_nxt_s     = NW'(0);
                        n_per_nxt_s      = NW'(0);
                        ok_cnt_nxt_s     = OK_W'(0);
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt_s  = ST_IDLE;
                    cnt_nxt_s    = CNT_W'(0);
                    sum_nxt_s    = SUM_W'(0);
                    n_long_nxt_s = NW'(0);
                    n_per_nxt_s  = NW'(0);
                    ok_cnt_nxt_s = OK_W'(0);
                end
            endcase
        end

        lock_nxt_s = (state_nxt_s == ST_LOCKED);
    end

    // State and output registers; the edge-detect delay runs even during clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            d_r          <= 1'b0;
            cnt_r        <= CNT_W'(0);
            sum_r        <= SUM_W'(0);
            n_long_r     <= NW'(0);
            n_per_r      <= NW'(0);
            ok_cnt_r     <= OK_W'(0);
            period_len_r <= CNT_W'(0);
            period_vld_r <= 1'b0;
            win_sum_r    <= SUM_W'(0);
            win_vld_r    <= 1'b0;
            win_ok_r     <= 1'b0;
            lock_r       <= 1'b0;
            err_period_r <= 1'b0;
            err_window_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            d_r          <= clk_div_in;
            cnt_r        <= cnt_nxt_s;
            sum_r        <= sum_nxt_s;
            n_long_r     <= n_long_nxt_s;
            n_per_r      <= n_per_nxt_s;
            ok_cnt_r     <= ok_cnt_nxt_s;
            period_len_r <= period_len_nxt_s;
            period_vld_r <= period_vld_nxt_s;
            win_sum_r    <= win_sum_nxt_s;
            win_vld_r    <= win_vld_nxt_s;
            win_ok_r     <= win_ok_nxt_s;
            lock_r       <= lock_nxt_s;
            err_period_r <= err_period_nxt_s;
            err_window_r <= err_window_nxt_s;
        end
    end

    assign period_len = period_len_r;
    assign period_vld = period_vld_r;
    assign win_sum    = win_sum_r;
    assign win_vld    = win_vld_r;
    assign win_ok     = win_ok_r;
    assign lock       = lock_r;
    assign err_period = err_period_r;
    assign err_window = err_window_r;

endmodule

// File: tb/tb_clk_div_frac_mon.sv
// ---------------------------------------------------------------------------
// tb_clk_div_frac_mon
//
// Drives divider-like waveforms into clk_div_frac_mon as a sequence of
// periods, which are given as lengths in clk cycles. A reference model
// looks at the periods as a list. It pushes one expected record per reported
// period into a scoreboard queue. A monitor pops the queue and compares each
// time the DUT pulses period_vld. Directed checks cover reset, clear, the
// timeout and the sticky flags.
// ---------------------------------------------------------------------------
module tb_clk_div_frac_mon;

    localparam int S_NUM    = 76;
    localparam int D_NUM    = 10;
    localparam int LOCK_WIN = 2;
    localparam int S_DIV    = S_NUM / D_NUM;
    localparam int D_DIV    = S_DIV + 1;
    localparam int ACC      = S_NUM - S_DIV * D_NUM;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clk_div_in;
    logic       clr;
    logic [3:0] period_len;
    logic       period_vld;
    logic [6:0] win_sum;
    logic       win_vld;
    logic       win_ok;
    logic       lock;
    logic       err_period;
    logic       err_window;

    clk_div_frac_mon #(.S_NUM(S_NUM), .D_NUM(D_NUM), .LOCK_WIN(LOCK_WIN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_div_in (clk_div_in),
        .clr        (clr),
        .period_len (period_len),
        .period_vld (period_vld),
        .win_sum    (win_sum),
        .win_vld    (win_vld),
        .win_ok     (win_ok),
        .lock       (lock),
        .err_period (err_period),
        .err_window (err_window)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int len;
        int win;
        int wsum;
        int wok;
        int lck;
        int errp;
        int errw;
    } exp_t;

    exp_t exp_q[$];
    int   win_q[$];     // periods of the current, unfinished window
    int   m_meas;       // a start edge has been seen
    int   m_ok;         // consecutive good windows, capped at LOCK_WIN
    int   m_errp;
    int   m_errw;
    int   prev_gap;     // cycles between the previous rise and the next one
    int   pk;           // position in the 7.6 pattern

    task automatic model_clear();
        m_meas = 0;
        win_q.delete();
        m_ok   = 0;
        m_errp = 0;
        m_errw = 0;
    endtask

    // Called once for every rising edge, with the gap since the previous rise
    task automatic model_rise(input int gap, input bit with_clr);
        exp_t e;
        int   s;
        int   nl;
        if (with_clr) begin
            model_clear();
        end else if (m_meas == 0) begin
            m_meas = 1;
        end else if (gap > D_DIV + 1) begin
            // Timed out before this rise; this rise starts a fresh measurement
            m_errp = 1;
            m_ok   = 0;
            win_q.delete();
        end else begin
            win_q.push_back(gap);
            e.len = gap; e.win = 0; e.wsum = 0; e.wok = 0;
            if (win_q.size() == D_NUM) begin
                s = 0; nl = 0;
                foreach (win_q[i]) begin
                    s += win_q[i];
                    if (win_q[i] == D_DIV) nl++;
                end
                e.win  = 1;
                e.wsum = s;
                e.wok  = (s == S_NUM && nl == ACC) ? 1 : 0;
                win_q.delete();
                if (e.wok == 1) m_ok = (m_ok + 1 > LOCK_WIN) ? LOCK_WIN : m_ok + 1;
                else begin
                    m_errw = 1;
                    m_ok   = 0;
                end
            end
            if (gap != S_DIV && gap != D_DIV) begin
                m_errp = 1;
                m_ok   = 0;
            end
            e.lck  = (m_ok == LOCK_WIN) ? 1 : 0;
            e.errp = m_errp;
            e.errw = m_errw;
            exp_q.push_back(e);
        end
    endtask

    function automatic int next_pat();
        int l;
        l  = ((pk + 1) * S_NUM) / D_NUM - (pk * S_NUM) / D_NUM;
        pk = (pk + 1) % D_NUM;
        return l;
    endfunction

    function automatic int outs_all();
        logic [16:0] v;
        v = {period_len, period_vld, win_sum, win_vld, win_ok, lock, err_period, err_window};
        return int'(v);
    endfunction

    // ---------------- drivers ----------------
    // One period: rise, high for len/2 cycles, then low until the next rise
    task automatic seg(input int len, input bit with_clr);
        model_rise(prev_gap, with_clr);
        clk_div_in = 1'b1;
        clr        = with_clr;
        @(posedge clk); #1;
        clr = 1'b0;
        for (int i = 1; i < len; i++) begin
            clk_div_in = (i < len / 2) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
        end
        prev_gap = len;
    endtask

    task automatic do_clr();
        clk_div_in = 1'b0;
        clr        = 1'b1;
        model_clear();
        @(posedge clk); #1;
        clr      = 1'b0;
        prev_gap = 0;
    endtask

    task automatic pulse_reset();
        #2;
        rst_n      = 1'b0;
        clk_div_in = 1'b0;
        @(negedge clk);
        chk("rst_async_outputs", outs_all(), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_outputs", outs_all(), 0);
        model_clear();
        prev_gap = 0;
        rst_n    = 1'b1;
        @(posedge clk); #1;
    endtask

    // ---------------- monitor ----------------
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (period_vld === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL period_vld_unexpected: got len %0d expected no period (t=%0t)",
                             period_len, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("period_len", int'(period_len), mon_e.len);
                    chk("win_vld", int'(win_vld), mon_e.win);
                    if (mon_e.win == 1) begin
                        chk("win_sum", int'(win_sum), mon_e.wsum);
                        chk("win_ok", int'(win_ok), mon_e.wok);
                    end
                    chk("lock", int'(lock), mon_e.lck);
                    chk("err_period", int'(err_period), mon_e.errp);
                    chk("err_window", int'(err_window), mon_e.errw);
                end
            end else begin
                chk("win_vld_stray", int'(win_vld), 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int l;
        rst_n = 1'b0; clk_div_in = 1'b0; clr = 1'b0;
        pk = 0; prev_gap = 0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", outs_all(), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: correct 7.6 divider from phase 0
        pk = 0;
        repeat (41) seg(next_pat(), 1'b0);
        chk("t1_lock", int'(lock), 1);
        chk("t1_err_period", int'(err_period), 0);
        chk("t1_err_window", int'(err_window), 0);

        // 2: start at an arbitrary phase
        do_clr();
        pk = $urandom_range(0, D_NUM - 1);
        repeat (41) seg(next_pat(), 1'b0);
        chk("t2_lock", int'(lock), 1);
        chk("t2_err_period", int'(err_period), 0);
        chk("t2_err_window", int'(err_window), 0);

        // 3: stretch one long period to 9 cycles while locked
        l = next_pat();
        while (l != D_DIV) begin
            seg(l, 1'b0);
            l = next_pat();
        end
        seg(D_DIV + 1, 1'b0);
        repeat (35) seg(next_pat(), 1'b0);
        chk("t3_relock", int'(lock), 1);
        chk("t3_err_period_sticky", int'(err_period), 1);
        chk("t3_err_window_sticky", int'(err_window), 1);

        // 4: stall the divider after locking
        do_clr();
        chk("t4_clr_flags", int'({err_period, err_window}), 0);
        repeat (25) seg(next_pat(), 1'b0);
        chk("t4_locked_before", int'(lock), 1);
        seg(25, 1'b0);
        chk("t4_timeout_lock", int'(lock), 0);
        chk("t4_timeout_err", int'(err_period), 1);
        repeat (25) seg(next_pat(), 1'b0);
        chk("t4_relock", int'(lock), 1);

        // 5: wrong ratio, every period 7
        do_clr();
        chk("t5_clr_flags", int'({err_period, err_window}), 0);
        repeat (41) seg(S_DIV, 1'b0);
        chk("t5_lock", int'(lock), 0);
        chk("t5_err_period", int'(err_period), 0);
        chk("t5_err_window", int'(err_window), 1);

        // 6: clear on a rise cycle, then a reset mid-period, then random traffic
        repeat (3) seg(next_pat(), 1'b0);
        seg(next_pat(), 1'b1);
        chk("t6_clr_outputs", outs_all(), 0);
        repeat (12) seg(next_pat(), 1'b0);
        pulse_reset();
        repeat (120) begin
            l = next_pat();
            if ($urandom_range(0, 7) == 0) l = $urandom_range(3, 12);
            seg(l, 1'b0);
        end
        chk("t6_lock", int'(lock), (m_ok == LOCK_WIN) ? 1 : 0);
        chk("t6_err_period", int'(err_period), m_errp);
        chk("t6_err_window", int'(err_window), m_errw);

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
